mul_issue_arb: RTL and testbench
================================

MUL_ISSUE_ARB -- requirements
Module: mul_issue_arb

Interface
REQ-001 SHALL have ports: clk  input  1  sole clock, all state updates on posedge.
REQ-002 SHALL have ports: rst  input  1  asynchronous, active-low reset (asserted when rst==0).
REQ-003 SHALL have: flush  input  1  pipeline flush.
REQ-004 SHALL have: freeze_back  input  1  back-end stall; the multiplier holds while high.
REQ-005 SHALL have, for N in {0,1}: valid_reqN  input  1  requester N presents a multiply op.
REQ-006 SHALL have, for N in {0,1}: Pw_reqN  input  5  physical destination register.
REQ-007 SHALL have, for N in {0,1}: tag_ROB_reqN  input  5  ROB tag.
REQ-008 SHALL have, for N in {0,1}: busA_reqN, busB_reqN  input  16 each  operands.
REQ-009 SHALL have: ready_req0, ready_req1  output  1 each  combinational grant; op accepted when valid_reqN && ready_reqN.
REQ-010 SHALL have: valid_mul, Pw_mul[4:0], tag_ROB_mul[4:0], busA_mul[15:0], busB_mul[15:0]  output  registered issue to the 2-stage multiplier.
REQ-011 SHALL have: valid_Result_mul  input  1  multiplier writeback valid, used for in-flight tracking.
REQ-012 SHALL have: inflight_cnt  output  2  ops accepted and not yet written back.
REQ-013 SHALL have: mul_idle  output  1  high when inflight_cnt==0.
REQ-014 SHALL have: perf_conflict_cnt  output  16  conflict counter (see Configuration).

Function
REQ-015 SHALL assert at most one ready_reqN per cycle, and only for a requester whose valid_reqN is high.
REQ-016 SHALL drive both ready outputs to 0 while flush or freeze_back is high; flush takes priority over freeze_back.
REQ-017 SHALL arbitrate round-robin using a 1-bit priority pointer prio (0 selects req0 first).
REQ-018 SHALL grant the only valid requester when exactly one is valid, regardless of prio.
REQ-019 SHALL, when both requesters are valid, grant requester prio.
REQ-020 SHALL, after any grant to requester N, set prio to the other requester; with no grant, prio holds.
REQ-021 SHALL, on an accept at edge t, drive that op's fields on the issue outputs with valid_mul=1 from t+1; the multiplier result then follows at t+3 with no stalls.
REQ-022 SHALL set valid_mul=0 on the next edge in any non-stalled cycle with no grant; the other issue fields hold their previous values.
REQ-023 SHALL hold all issue outputs and prio unchanged while freeze_back=1 and flush=0.
REQ-024 SHALL, on flush, clear valid_mul and the other issue fields to 0, hold prio, and clear inflight_cnt to 0.
REQ-025 SHALL increment inflight_cnt on an accept.
REQ-026 SHALL decrement inflight_cnt when valid_Result_mul=1 and freeze_back=0.
REQ-027 SHALL leave inflight_cnt unchanged when an increment and a decrement occur in the same cycle.
REQ-028 SHALL keep inflight_cnt within 0..3: no grant is issued at 3, and no decrement occurs at 0.
REQ-029 SHALL keep throughput at one accept per cycle when not stalled.

Reset
REQ-030 SHALL, on rst low, immediately clear valid_mul, Pw_mul, tag_ROB_mul, busA_mul, busB_mul, prio, inflight_cnt and perf_conflict_cnt to 0.
REQ-031 SHALL, while rst is low, drive ready_req0=ready_req1=0 and mul_idle=1.
REQ-032 SHALL, when reset asserts mid-operation, discard any in-flight ops with no residual state.

Configuration
REQ-033 SHALL support macro MUL_ARB_PERF_EN.
REQ-034 SHALL, when MUL_ARB_PERF_EN is defined, increment perf_conflict_cnt in each cycle where both valid_reqN=1, flush=0 and freeze_back=0; the counter saturates at 16'hFFFF.
REQ-035 SHALL, when MUL_ARB_PERF_EN is undefined, tie perf_conflict_cnt to 0 and implement no counter logic.

Verification
REQ-036 SHALL cover: only valid_req0 with Pw=3, tag=7, A=16'h0005, B=16'h0006 accepted at edge t -> valid_mul=1 with those fields at t+1, inflight_cnt=1.
REQ-037 SHALL cover: both requesters valid for 4 cycles from reset -> grants in order req0, req1, req0, req1; perf_conflict_cnt=4 with MUL_ARB_PERF_EN defined, 0 without.
REQ-038 SHALL cover: freeze_back high for 3 cycles with valid_mul=1 -> issue outputs unchanged, ready=0, inflight_cnt constant, then resume on release.
REQ-039 SHALL cover: 3 accepts with no valid_Result_mul -> inflight_cnt=3, ready=0 next cycle; one valid_Result_mul pulse -> 2, grants resume.
REQ-040 SHALL cover: flush together with valid_req1 -> ready_req1=0, valid_mul=0 next edge, inflight_cnt=0, prio unchanged.
REQ-041 SHALL cover: rst pulled low mid-stream between edges -> all outputs cleared immediately, mul_idle=1.

Source files
------------

// File: rtl/mul_issue_arb.sv
// mul_issue_arb: two-requester round-robin issue arbiter in front of a 2-stage multiplier,
// with in-flight tracking (max 3). Optional conflict counter enabled by macro MUL_ARB_PERF_EN.
module mul_issue_arb (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        freeze_back,
    input  logic        valid_req0,
    input  logic [4:0]  Pw_req0,
    input  logic [4:0]  tag_ROB_req0,
    input  logic [15:0] busA_req0,
    input  logic [15:0] busB_req0,
    input  logic        valid_req1,
    input  logic [4:0]  Pw_req1,
    input  logic [4:0]  tag_ROB_req1,
    input  logic [15:0] busA_req1,
    input  logic [15:0] busB_req1,
    output logic        ready_req0,
    output logic        ready_req1,
    output logic        valid_mul,
    output logic [4:0]  Pw_mul,
    output logic [4:0]  tag_ROB_mul,
    output logic [15:0] busA_mul,
    output logic [15:0] busB_mul,
    input  logic        valid_Result_mul,
    output logic [1:0]  inflight_cnt,
    output logic        mul_idle,
    output logic [15:0] perf_conflict_cnt
);

    localparam logic [1:0] INFLIGHT_MAX = 2'd3;

    logic prio;
    logic can_grant;
    logic grant0;
    logic grant1;
    logic accept;
    logic retire;

    // Handshake: an op transfers on a cycle where valid_reqN && ready_reqN; ready is a
    // combinational grant that never depends on the requester withdrawing valid.
    assign can_grant  = rst && !flush && !freeze_back && (inflight_cnt != INFLIGHT_MAX);
    assign grant0     = can_grant && valid_req0 && (!valid_req1 || !prio);
    assign grant1     = can_grant && valid_req1 && (!valid_req0 || prio);
    assign ready_req0 = grant0;
    assign ready_req1 = grant1;

    assign accept   = grant0 || grant1;
    assign retire   = valid_Result_mul && !freeze_back && (inflight_cnt != 2'd0);
    assign mul_idle = (inflight_cnt == 2'd0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_mul    <= 1'b0;
            Pw_mul       <= '0;
            tag_ROB_mul  <= '0;
            busA_mul     <= '0;
            busB_mul     <= '0;
            prio         <= 1'b0;
            inflight_cnt <= '0;
        end else if (flush) begin
            // Flush drops every op in the pipe but keeps fairness state.
            valid_mul    <= 1'b0;
            Pw_mul       <= '0;
            tag_ROB_mul  <= '0;
            busA_mul     <= '0;
            busB_mul     <= '0;
            inflight_cnt <= '0;
        end else if (!freeze_back) begin
            valid_mul <= accept;
            if (grant0) begin
                Pw_mul      <= Pw_req0;
                tag_ROB_mul <= tag_ROB_req0;
                busA_mul    <= busA_req0;
                busB_mul    <= busB_req0;
                prio        <= 1'b1;
            end else if (grant1) begin
                Pw_mul      <= Pw_req1;
                tag_ROB_mul <= tag_ROB_req1;
                busA_mul    <= busA_req1;
                busB_mul    <= busB_req1;
                prio        <= 1'b0;
            end
            if (accept && !retire) begin
                inflight_cnt <= inflight_cnt + 2'd1;
            end else if (!accept && retire) begin
                inflight_cnt <= inflight_cnt - 2'd1;
            end
        end
    end

`ifdef MUL_ARB_PERF_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_conflict_cnt <= '0;
        end else if (valid_req0 && valid_req1 && !flush && !freeze_back &&
                     (perf_conflict_cnt != 16'hFFFF)) begin
            perf_conflict_cnt <= perf_conflict_cnt + 16'd1;
        end
    end
`else
    assign perf_conflict_cnt = '0;
`endif

endmodule

// File: tb/tb_mul_issue_arb.sv
// tb_mul_issue_arb: directed scenarios plus randomized traffic against an in-bench model
// that tracks in-flight ops as a queue and the last issued op as plain fields.
module tb_mul_issue_arb;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush, freeze_back;
    logic        valid_req0, valid_req1;
    logic [4:0]  Pw_req0, Pw_req1, tag_ROB_req0, tag_ROB_req1;
    logic [15:0] busA_req0, busA_req1, busB_req0, busB_req1;
    logic        ready_req0, ready_req1;
    logic        valid_mul;
    logic [4:0]  Pw_mul, tag_ROB_mul;
    logic [15:0] busA_mul, busB_mul;
    logic        valid_Result_mul;
    logic [1:0]  inflight_cnt;
    logic        mul_idle;
    logic [15:0] perf_conflict_cnt;

    mul_issue_arb dut (
        .clk(clk), .rst(rst), .flush(flush), .freeze_back(freeze_back),
        .valid_req0(valid_req0), .Pw_req0(Pw_req0), .tag_ROB_req0(tag_ROB_req0),
        .busA_req0(busA_req0), .busB_req0(busB_req0),
        .valid_req1(valid_req1), .Pw_req1(Pw_req1), .tag_ROB_req1(tag_ROB_req1),
        .busA_req1(busA_req1), .busB_req1(busB_req1),
        .ready_req0(ready_req0), .ready_req1(ready_req1),
        .valid_mul(valid_mul), .Pw_mul(Pw_mul), .tag_ROB_mul(tag_ROB_mul),
        .busA_mul(busA_mul), .busB_mul(busB_mul),
        .valid_Result_mul(valid_Result_mul), .inflight_cnt(inflight_cnt),
        .mul_idle(mul_idle), .perf_conflict_cnt(perf_conflict_cnt)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // ---------------- model ----------------
    logic [41:0] exp_q[$];      // ops accepted and not yet written back
    logic        m_prio;
    logic        m_valid;
    logic [41:0] m_issue;       // {Pw, tag, A, B} currently on the issue outputs
    int          m_perf;

    task automatic model_reset();
        exp_q.delete();
        m_prio  = 1'b0;
        m_valid = 1'b0;
        m_issue = '0;
        m_perf  = 0;
    endtask

    function automatic int exp_grant();
        if (!rst || flush || freeze_back || exp_q.size() >= 3) return -1;
        if (valid_req0 && valid_req1) return m_prio ? 1 : 0;
        if (valid_req0) return 0;
        if (valid_req1) return 1;
        return -1;
    endfunction

    task automatic model_step();
        int g;
        g = exp_grant();
        if (!rst) begin
            model_reset();
            return;
        end
`ifdef MUL_ARB_PERF_EN
        if (valid_req0 && valid_req1 && !flush && !freeze_back && m_perf < 65535) m_perf++;
`endif
        if (flush) begin
            m_valid = 1'b0;
            m_issue = '0;
            exp_q.delete();
        end else if (!freeze_back) begin
            if (valid_Result_mul && exp_q.size() > 0) void'(exp_q.pop_front());
            if (g == 0) m_issue = {Pw_req0, tag_ROB_req0, busA_req0, busB_req0};
            if (g == 1) m_issue = {Pw_req1, tag_ROB_req1, busA_req1, busB_req1};
            if (g >= 0) begin
                exp_q.push_back(m_issue);
                m_prio = (g == 0);
            end
            m_valid = (g >= 0);
        end
    endtask

    // ---------------- scoreboard ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all();
        int g;
        g = exp_grant();
        chk("ready_req0", 32'(ready_req0), 32'(g == 0));
        chk("ready_req1", 32'(ready_req1), 32'(g == 1));
        chk("valid_mul", 32'(valid_mul), 32'(m_valid));
        chk("issue_fields", 32'({Pw_mul, tag_ROB_mul, busA_mul[5:0]}), 32'({m_issue[41:32], m_issue[21:16]}));
        chk("busA_mul", 32'(busA_mul), 32'(m_issue[31:16]));
        chk("busB_mul", 32'(busB_mul), 32'(m_issue[15:0]));
        chk("inflight_cnt", 32'(inflight_cnt), 32'(exp_q.size()));
        chk("mul_idle", 32'(mul_idle), 32'(exp_q.size() == 0));
        chk("perf_conflict_cnt", 32'(perf_conflict_cnt), 32'(m_perf));
    endtask

    // ---------------- driver tasks ----------------
    task automatic cycle();
        @(negedge clk);
        check_all();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle_inputs();
        flush = 0; freeze_back = 0; valid_Result_mul = 0;
        valid_req0 = 0; Pw_req0 = 0; tag_ROB_req0 = 0; busA_req0 = 0; busB_req0 = 0;
        valid_req1 = 0; Pw_req1 = 0; tag_ROB_req1 = 0; busA_req1 = 0; busB_req1 = 0;
    endtask

    task automatic set_req(input int n, input logic v, input logic [4:0] pw,
                           input logic [4:0] tag, input logic [15:0] a, input logic [15:0] b);
        if (n == 0) begin
            valid_req0 = v; Pw_req0 = pw; tag_ROB_req0 = tag; busA_req0 = a; busB_req0 = b;
        end else begin
            valid_req1 = v; Pw_req1 = pw; tag_ROB_req1 = tag; busA_req1 = a; busB_req1 = b;
        end
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 0;
        #1;
        model_reset();
        cycle();
        rst = 1;
    endtask

    logic exp_r0 [4];

    initial begin
        idle_inputs();
        model_reset();
        valid_req0 = 1;
        #1 rst = 0;
        #1;
        chk("rst_valid_mul", 32'(valid_mul), 32'd0);
        chk("rst_inflight", 32'(inflight_cnt), 32'd0);
        chk("rst_mul_idle", 32'(mul_idle), 32'd1);
        chk("rst_ready0", 32'(ready_req0), 32'd0);
        chk("rst_perf", 32'(perf_conflict_cnt), 32'd0);
        do_reset();

        // single requester, then freeze with an op on the issue outputs
        set_req(0, 1, 5'd3, 5'd7, 16'h0005, 16'h0006);
        #1 chk("t36_ready0", 32'(ready_req0), 32'd1);
        cycle();
        set_req(0, 0, 0, 0, 0, 0);
        chk("t36_valid_mul", 32'(valid_mul), 32'd1);
        chk("t36_Pw", 32'(Pw_mul), 32'd3);
        chk("t36_tag", 32'(tag_ROB_mul), 32'd7);
        chk("t36_A", 32'(busA_mul), 32'h5);
        chk("t36_B", 32'(busB_mul), 32'h6);
        chk("t36_inflight", 32'(inflight_cnt), 32'd1);
        freeze_back = 1;
        set_req(1, 1, 5'd9, 5'd2, 16'h1111, 16'h2222);
        for (int i = 0; i < 3; i++) begin
            #1 chk("t38_ready1", 32'(ready_req1), 32'd0);
            cycle();
            chk("t38_valid_mul", 32'(valid_mul), 32'd1);
            chk("t38_Pw", 32'(Pw_mul), 32'd3);
            chk("t38_inflight", 32'(inflight_cnt), 32'd1);
        end
        freeze_back = 0;
        #1 chk("t38_resume_ready1", 32'(ready_req1), 32'd1);
        cycle();
        set_req(1, 0, 0, 0, 0, 0);
        chk("t38_resume_Pw", 32'(Pw_mul), 32'd9);
        chk("t38_resume_inflight", 32'(inflight_cnt), 32'd2);

        // both valid from reset: alternate grants starting at req0
        do_reset();
        set_req(0, 1, 5'd1, 5'd1, 16'h00A0, 16'h00B0);
        set_req(1, 1, 5'd2, 5'd2, 16'h00A1, 16'h00B1);
        exp_r0 = '{1'b1, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            valid_Result_mul = (i != 0);
            #1 chk("t37_grant_order", 32'({ready_req0, ready_req1}), 32'({exp_r0[i], !exp_r0[i]}));
            cycle();
        end
        idle_inputs();
`ifdef MUL_ARB_PERF_EN
        chk("t37_perf", 32'(perf_conflict_cnt), 32'd4);
`else
        chk("t37_perf", 32'(perf_conflict_cnt), 32'd0);
`endif
        chk("t37_inflight", 32'(inflight_cnt), 32'd1);

        // in-flight limit
        do_reset();
        set_req(0, 1, 5'd4, 5'd4, 16'h0044, 16'h0045);
        repeat (3) cycle();
        chk("t39_inflight3", 32'(inflight_cnt), 32'd3);
        #1 chk("t39_ready_blocked", 32'(ready_req0), 32'd0);
        cycle();
        chk("t39_valid_mul_drop", 32'(valid_mul), 32'd0);
        valid_Result_mul = 1;
        cycle();
        valid_Result_mul = 0;
        chk("t39_inflight2", 32'(inflight_cnt), 32'd2);
        #1 chk("t39_ready_resume", 32'(ready_req0), 32'd1);
        cycle();
        chk("t39_inflight_back3", 32'(inflight_cnt), 32'd3);

        // flush: prio must survive
        do_reset();
        set_req(0, 1, 5'd5, 5'd5, 16'h0055, 16'h0056);
        cycle();
        flush = 1;
        set_req(1, 1, 5'd6, 5'd6, 16'h0066, 16'h0067);
        #1 chk("t40_ready1", 32'(ready_req1), 32'd0);
        cycle();
        flush = 0;
        chk("t40_valid_mul", 32'(valid_mul), 32'd0);
        chk("t40_inflight", 32'(inflight_cnt), 32'd0);
        chk("t40_Pw_cleared", 32'(Pw_mul), 32'd0);
        #1 chk("t40_prio_held", 32'({ready_req0, ready_req1}), 32'b01);
        cycle();
        idle_inputs();

        // async reset between edges
        set_req(0, 1, 5'd8, 5'd8, 16'h0088, 16'h0089);
        cycle();
        cycle();
        #2 rst = 0;
        #1;
        chk("t41_valid_mul", 32'(valid_mul), 32'd0);
        chk("t41_fields", 32'({Pw_mul, tag_ROB_mul, busA_mul, busB_mul}), 32'd0);
        chk("t41_inflight", 32'(inflight_cnt), 32'd0);
        chk("t41_mul_idle", 32'(mul_idle), 32'd1);
        chk("t41_ready0", 32'(ready_req0), 32'd0);
        model_reset();
        cycle();
        rst = 1;
        idle_inputs();

        // randomized traffic
        for (int i = 0; i < 2000; i++) begin
            set_req(0, $urandom_range(0, 3) != 0, 5'($urandom), 5'($urandom),
                    16'($urandom), 16'($urandom));
            set_req(1, $urandom_range(0, 3) != 0, 5'($urandom), 5'($urandom),
                    16'($urandom), 16'($urandom));
            flush            = ($urandom_range(0, 39) == 0);
            freeze_back      = ($urandom_range(0, 7) == 0);
            valid_Result_mul = ($urandom_range(0, 2) != 0);
            cycle();
        end
        idle_inputs();
        cycle();

        // ---------------- report ----------------
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
